// File: rtl/cfg_status_reg_bank_if.sv
// Request/response bus between the AXI-lite front-end (master) and the
// configuration/status register bank (slave).
interface cfg_status_reg_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/cfg_status_reg_bank.sv
// Parametrised config/status register bank with per-bit RW/W1C/WO/RC/RO/PULSE
// classes, sticky hardware event capture and a level interrupt.
module cfg_status_reg_bank #(
    parameter int unsigned                    DATA_W     = 32,
    parameter int unsigned                    ADDR_W     = 32,
    parameter int unsigned                    NUM_REGS   = 2,
    parameter logic [NUM_REGS*ADDR_W-1:0]     REG_ADDR   = {32'h8, 32'h0},
    parameter logic [NUM_REGS*DATA_W-1:0]     RW_MASK    = {32'hF, 32'h07FFFFFC},
    parameter logic [NUM_REGS*DATA_W-1:0]     W1C_MASK   = {32'h03FE0000, 32'h0},
    parameter logic [NUM_REGS*DATA_W-1:0]     WO_MASK    = {32'hF0, 32'h3},
    parameter logic [NUM_REGS*DATA_W-1:0]     RC_MASK    = {32'hF000, 32'hC0000000},
    parameter logic [NUM_REGS*DATA_W-1:0]     RO_MASK    = {32'hF00, 32'h30000000},
    parameter logic [NUM_REGS*DATA_W-1:0]     PULSE_MASK = {32'h80010000, 32'h08000000},
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    cfg_status_reg_bank_if.slave         bus,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
    output logic [NUM_REGS*DATA_W-1:0]   pulse_out,
    output logic                         irq
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] mask_of(input logic [NUM_REGS*DATA_W-1:0] m,
                                                  input int unsigned r);
        return m[r*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int unsigned r);
        return REG_ADDR[r*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            m[b*8 +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

    // A bit may belong to at most one class.
    function automatic logic has_overlap(input int unsigned r);
        logic [DATA_W-1:0] seen;
        logic [DATA_W-1:0] ovl;
        seen = mask_of(RW_MASK, r);
        ovl  = seen & mask_of(W1C_MASK, r);
        seen = seen | mask_of(W1C_MASK, r);
        ovl  = ovl | (seen & mask_of(WO_MASK, r));
        seen = seen | mask_of(WO_MASK, r);
        ovl  = ovl | (seen & mask_of(RC_MASK, r));
        seen = seen | mask_of(RC_MASK, r);
        ovl  = ovl | (seen & mask_of(RO_MASK, r));
        seen = seen | mask_of(RO_MASK, r);
        ovl  = ovl | (seen & mask_of(PULSE_MASK, r));
        return |ovl;
    endfunction

    state_e                      state_q, state_d;
    logic                        ready_q, ready_d;
    logic                        rvalid_q, rvalid_d;
    logic [DATA_W-1:0]           rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [DATA_W-1:0]           store_q [NUM_REGS];
    logic [DATA_W-1:0]           store_d [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0]  pulse_q, pulse_d;
    logic                        irq_q, irq_d;
    logic [NUM_REGS-1:0]         sel;
    logic [DATA_W-1:0]           wmask;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of 8");
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (has_overlap(g)) begin : g_overlap
            $error("overlapping bit-class masks in register %0d", g);
        end
        assign cfg_out[g*DATA_W +: DATA_W] =
            store_q[g] & (mask_of(RW_MASK, g) | mask_of(WO_MASK, g));
    end

    // Next-state: FSM, register updates on accept, sticky capture, irq.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        store_d  = store_q;
        pulse_d  = '0;
        irq_d    = 1'b0;
        sel      = '0;
        wmask    = strb_to_mask(bus.req_wstrb);

        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            sel[r] = (bus.req_addr == addr_of(r));
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d  = S_RESP;
                    ready_d  = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = ~(|sel);
                    rdata_d  = '0;
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        if (sel[r]) begin
                            if (bus.req_write) begin
                                store_d[r] = (store_q[r]
                                    & ~(wmask & (mask_of(RW_MASK, r) | mask_of(WO_MASK, r)))
                                    & ~(bus.req_wdata & wmask & mask_of(W1C_MASK, r)))
                                    | (bus.req_wdata & wmask
                                       & (mask_of(RW_MASK, r) | mask_of(WO_MASK, r)));
                                pulse_d[r*DATA_W +: DATA_W] =
                                    bus.req_wdata & wmask & mask_of(PULSE_MASK, r);
                            end else begin
                                rdata_d = (store_q[r] & (mask_of(RW_MASK, r)
                                           | mask_of(W1C_MASK, r) | mask_of(RC_MASK, r)))
                                        | (hw_status[r*DATA_W +: DATA_W] & mask_of(RO_MASK, r));
                                store_d[r] = store_q[r] & ~mask_of(RC_MASK, r);
                            end
                        end
                    end
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Hardware set is applied last so it wins over a same-cycle clear.
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            store_d[r] = store_d[r] | (hw_set[r*DATA_W +: DATA_W]
                         & (mask_of(W1C_MASK, r) | mask_of(RC_MASK, r)));
            irq_d = irq_d | (|(store_q[r] & mask_of(W1C_MASK, r)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            pulse_q  <= '0;
            irq_q    <= 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                store_q[r] <= mask_of(RESET_VAL, r)
                              & (mask_of(RW_MASK, r) | mask_of(WO_MASK, r));
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            irq_q    <= irq_d;
            store_q  <= store_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rvalid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign pulse_out     = pulse_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_cfg_status_reg_bank.sv
// Directed self-checking bench for cfg_status_reg_bank with default parameters.
module tb_cfg_status_reg_bank;
    logic        clk;
    logic        rst;
    logic [63:0] hw_status;
    logic [63:0] hw_set;
    logic [63:0] cfg_out;
    logic [63:0] pulse_out;
    logic        irq;

    int checks;
    int errors;

    cfg_status_reg_bank_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    cfg_status_reg_bank dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .hw_status (hw_status),
        .hw_set    (hw_set),
        .cfg_out   (cfg_out),
        .pulse_out (pulse_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and return #1 after the accept edge.
    task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [63:0] set_v);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        hw_set        = set_v;
        while (!bus.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_in_time", 64'(n < 16), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        hw_set        = '0;
    endtask

    // Full transaction with rsp_ready high; captures response and pulses.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [63:0] set_v,
                        output logic [31:0] rd, output logic err, output logic [63:0] pls);
        start_req(wr, a, d, s, set_v);
        check_eq("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        pls = pulse_out;
        @(posedge clk);
        #1;
        check_eq("pulse_one_cycle", pulse_out, 64'd0);
    endtask

    logic [31:0] rd;
    logic        err;
    logic [63:0] pls;

    initial begin
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        hw_status     = '0;
        hw_set        = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check_eq("rst_pulse_out", pulse_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: read after reset
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t1_rdata", 64'(rd), 64'h0);
        check_eq("t1_err", 64'(err), 64'd0);
        check_eq("t1_cfg_out", cfg_out, 64'h0);
        check_eq("t1_irq", 64'(irq), 64'd0);

        // 2: full write to reg 0, then read with RO status
        xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 64'h0, rd, err, pls);
        check_eq("t2_wr_rdata", 64'(rd), 64'h0);
        check_eq("t2_wr_err", 64'(err), 64'd0);
        check_eq("t2_pulse", pls, 64'h0000_0000_0800_0000);
        check_eq("t2_cfg_out", cfg_out, 64'h0000_0000_07FF_FFFF);
        hw_status = 64'h0000_0000_3000_0000;
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t2_rd_rdata", 64'(rd), 64'h37FF_FFFC);
        hw_status = '0;

        // 3: sticky capture; bit 0 of reg 1 is RW so hw_set must not touch it
        @(negedge clk);
        hw_set = 64'h0002_1001_0000_0000;
        @(posedge clk);
        #1;
        hw_set = '0;
        check_eq("t3_irq_lag", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t3_irq", 64'(irq), 64'd1);
        check_eq("t3_cfg_rw_ignored", cfg_out, 64'h0000_0000_07FF_FFFF);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t3_rd1", 64'(rd), 64'h0002_1000);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t3_rd2_rc_cleared", 64'(rd), 64'h0002_0000);

        // 4: W1C clear colliding with hw_set, then a plain clear
        xfer(1'b1, 32'h8, 32'h0002_0000, 4'hF, 64'h0002_0000_0000_0000, rd, err, pls);
        check_eq("t4_irq_held", 64'(irq), 64'd1);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t4_set_wins", 64'(rd), 64'h0002_0000);
        xfer(1'b1, 32'h8, 32'h0002_0000, 4'hF, 64'h0, rd, err, pls);
        check_eq("t4_irq_cleared", 64'(irq), 64'd0);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t4_bit_cleared", 64'(rd), 64'h0);
        xfer(1'b1, 32'h8, 32'h8001_0000, 4'hF, 64'h0, rd, err, pls);
        check_eq("t4_pulse_reg1", pls, 64'h8001_0000_0000_0000);

        // 5: single byte-lane write
        xfer(1'b1, 32'h0, 32'hAAAA_AAAA, 4'h1, 64'h0, rd, err, pls);
        check_eq("t5_cfg_out", cfg_out, 64'h0000_0000_07FF_FFAA);
        check_eq("t5_no_pulse", pls, 64'h0);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t5_rdata", 64'(rd), 64'h07FF_FFA8);

        // 6a: stalled response holds data; a request held in RESP is not taken
        bus.rsp_ready = 1'b0;
        hw_status = 64'h0000_0000_1000_0000;
        start_req(1'b0, 32'h0, 32'h0, 4'hF, 64'h0);
        hw_status = 64'h0000_0000_2000_0000;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("t6_stall_rdata", 64'(bus.rsp_rdata), 64'h17FF_FFA8);
        end
        check_eq("t6_stall_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("t6_stall_ready", 64'(bus.req_ready), 64'd0);
        check_eq("t6_no_double_apply", cfg_out, 64'h0000_0000_07FF_FFAA);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_release_valid", 64'(bus.rsp_valid), 64'd0);
        hw_status = '0;

        // 6b: unmapped address
        xfer(1'b0, 32'h4, 32'h0, 4'hF, 64'h0, rd, err, pls);
        check_eq("t6_unmapped_err", 64'(err), 64'd1);
        check_eq("t6_unmapped_rdata", 64'(rd), 64'h0);
        xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 64'h0, rd, err, pls);
        check_eq("t6_unmapped_wr_err", 64'(err), 64'd1);
        check_eq("t6_unmapped_no_pulse", pls, 64'h0);
        check_eq("t6_unmapped_no_change", cfg_out, 64'h0000_0000_07FF_FFAA);

        // 6c: reset during RESP
        bus.rsp_ready = 1'b0;
        start_req(1'b0, 32'h0, 32'h0, 4'hF, 64'h0);
        check_eq("t6_in_resp", 64'(bus.rsp_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("t6_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("t6_rst_cfg_out", cfg_out, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cfg_status_reg_bank.md
Name: cfg_status_reg_bank

Overview:
Parametrised configuration/status register bank. It implements NUM_REGS registers, and each bit is classified per register as RW, W1C, WO, RC, RO or PULSE through mask parameters. The bank sits behind the AXI-lite slave front-end on a simple valid/ready request/response bus. It exports config and pulse bits to the datapath, captures hardware events into sticky bits and raises a level interrupt.

Parameters:
DATA_W, 32, register and bus data width (multiple of 8)
ADDR_W, 32, bus address width
NUM_REGS, 2, number of registers
REG_ADDR, {32'h8,32'h0}, NUM_REGS*ADDR_W flattened byte address per register; index 0 is in the LSBs
RW_MASK, {32'hF,32'h07FFFFFC}, flattened read/write bit mask
W1C_MASK, {32'h03FE0000,32'h0}, flattened write-1-to-clear sticky bit mask
WO_MASK, {32'hF0,32'h3}, flattened write-only bit mask
RC_MASK, {32'hF000,32'hC0000000}, flattened read-clear sticky bit mask
RO_MASK, {32'hF00,32'h30000000}, flattened read-only (hw_status) bit mask
PULSE_MASK, {32'h80010000,32'h08000000}, flattened self-clearing pulse bit mask
RESET_VAL, '0, flattened reset value for RW/WO bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  unmapped address
hw_status  in  NUM_REGS*DATA_W  live values for RO bits
hw_set  in  NUM_REGS*DATA_W  one-cycle event set for W1C/RC bits
cfg_out  out  NUM_REGS*DATA_W  stored RW|WO bits; other bits 0
pulse_out  out  NUM_REGS*DATA_W  one-cycle pulses on PULSE bits
irq  out  1  OR of all set W1C bits

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high.
- Reset state: FSM IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. All RW/WO bits take RESET_VAL. W1C, RC and pulse bits are 0, and irq=0.
- Reset asserted mid-transaction drops any pending response. Writes not yet applied are discarded.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, the request is latched, its effect is applied at that same edge, and the FSM moves to RESP.
- FSM RESP:
  - req_ready=0 and rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_ready. The FSM then returns to IDLE.
  - Max throughput is one transaction per 2 cycles. Response latency is 1 cycle after accept.
- Address decode:
  - Exact match of req_addr against REG_ADDR entries.
  - No match: rsp_err=1, rdata=0, no state change, no pulses, no clears.
- Write, per byte lane with strobe=1:
  - RW/WO bits load wdata.
  - W1C bits with wdata=1 clear.
  - PULSE bits with wdata=1 drive pulse_out high for exactly the cycle after accept, then 0.
  - RC/RO bits are unaffected.
  - Lanes with strobe=0 are untouched.
- Read data is sampled at accept:
  - RW, W1C and RC bits return stored values.
  - RO bits return hw_status.
  - WO, PULSE and unclassified bits return 0.
- Read clear: RC bits of the addressed register clear at the accept edge. The pre-clear value is returned.
- Sticky capture: hw_set=1 on a W1C/RC bit sets it. hw_set on other bit classes is ignored.
- Simultaneous set and clear: if hw_set and a W1C clear or RC read-clear hit the same bit in one cycle, set wins and the bit stays 1. The read still returns the pre-edge value.
- Mask rules: masks are disjoint per bit. Overlap is a configuration error, flagged by an elaboration-time assertion.
- irq is registered and follows W1C state with a 1-cycle lag.
- Backpressure: a request held while in RESP is not accepted, and no double-apply occurs.

Test Plan:
1. After reset, read 0x0 with hw_status[31:0]=0 -> rdata=0x0, rsp_err=0, cfg_out=0, irq=0.
2. Write 0xFFFFFFFF, wstrb=0xF to 0x0 -> cfg_out[31:0]=0x07FFFFFF and pulse_out[27] high exactly 1 cycle. A subsequent read with hw_status[31:0]=0x30000000 -> rdata=0x37FFFFFC.
3. Pulse hw_set[63:32]=0x00021000 for 1 cycle -> irq=1 two cycles later. Read 0x8 -> rdata bits 17 and 12 set. A second read returns bit 17 only (RC bit 12 cleared).
4. Write 0x00020000 to 0x8 with hw_set bit 17 asserted the same cycle -> bit 17 remains 1 and irq stays 1. Repeat without hw_set -> bit cleared and irq=0.
5. Write 0xAAAAAAAA with wstrb=0x1 to 0x0 -> only byte 0 RW/WO bits change: cfg_out[7:0]=0xAA, upper bytes unchanged.
6. Hold rsp_ready=0 for 5 cycles, then read 0x4, then assert rst during RESP -> rdata stable while stalled. Read 0x4 gives rsp_err=1, rdata=0, no state change. Reset returns rsp_valid=0, req_ready=1 next cycle.
